// File: rtl/adc_pkg.sv
// Shared definitions for the ADC capture path.
//  ADC_W          width of one ADC conversion result
//  CSR_STOP_WORD  sequencer CSR word that halts conversion
//  state_t        capture controller states
package adc_pkg;

    localparam int          ADC_W         = 12;
    localparam logic [31:0] CSR_STOP_WORD = 32'h0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOCK,
        CFG_RUN,
        CAPTURE,
        CFG_STOP,
        DONE
    } state_t;

endpackage

// File: rtl/adc_avg_window.sv
// Windowed average of captured ADC samples.
// Sums 2**AVG_LOG2 consecutive samples, then publishes sum >> AVG_LOG2 (truncated)
// and restarts the sum from zero. avg_out/led hold between windows and captures.
//  clk, rst       clock, async active-low reset
//  clear          drop any partial window (start of a new capture)
//  sample_valid   sample is part of the capture
//  sample         ADC sample
//  avg_out        latest window average
//  avg_valid      1-cycle pulse when avg_out updates
//  led            avg_out[11:4]
module adc_avg_window
    import adc_pkg::*;
#(
    parameter int AVG_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] sample,
    output logic [ADC_W-1:0] avg_out,
    output logic             avg_valid,
    output logic [7:0]       led
);

    localparam int               ACC_W = ADC_W + AVG_LOG2;
    localparam int               CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'((2 ** AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] shifted;

    // The window's full sum never exceeds ACC_W bits, so no overflow is possible.
    always_comb begin
        sum     = acc + ACC_W'(sample);
        shifted = sum >> AVG_LOG2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            cnt       <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            led       <= '0;
        end else begin
            avg_valid <= 1'b0;
            if (clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (sample_valid) begin
                if (cnt == LAST) begin
                    avg_out   <= shifted[ADC_W-1:0];
                    led       <= shifted[ADC_W-1 -: 8];
                    avg_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: waits for PLL lock, starts the ADC sequencer via its CSR,
// streams valid samples into RAM at an incrementing (wrapping) address, stops the
// sequencer after NUM_SAMPLES (one-shot), on stop, or on PLL lock loss, and feeds
// captured samples to a windowed averager that drives the LEDs.
//  clk, rst                      clock, async active-low reset
//  start, stop, continuous       capture control (stop wins over start)
//  pll_locked                    ADC PLL lock
//  csr_address/write/writedata   sequencer CSR master
//  adc_valid, adc_data           ADC response stream
//  ram_addr, ram_data, ram_wren  RAM write port
//  avg_out, avg_valid, led       window average
//  busy, done, lock_lost         status
module adc_capture_ctrl
    import adc_pkg::*;
#(
    parameter int          ADDR_W       = 8,
    parameter int          NUM_SAMPLES  = 256,
    parameter int          AVG_LOG2     = 4,
    parameter logic [31:0] CSR_RUN_WORD = 32'h3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic              pll_locked,
    output logic              csr_address,
    output logic              csr_write,
    output logic [31:0]       csr_writedata,
    input  logic              adc_valid,
    input  logic [ADC_W-1:0]  adc_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [ADC_W-1:0]  ram_data,
    output logic              ram_wren,
    output logic [ADC_W-1:0]  avg_out,
    output logic              avg_valid,
    output logic [7:0]        led,
    output logic              busy,
    output logic              done,
    output logic              lock_lost
);

    // One extra bit so NUM_SAMPLES == 2**ADDR_W is representable.
    localparam int               CNT_W       = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(NUM_SAMPLES - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  sample_cnt;
    logic              cont_mode;
    logic              capture_sample;
    logic              enter_run;

    assign csr_address    = 1'b0;
    assign capture_sample = (state == CAPTURE) && adc_valid;
    assign enter_run      = (state == WAIT_LOCK) && !stop && pll_locked;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            csr_write     <= 1'b0;
            csr_writedata <= '0;
            ram_addr      <= '0;
            ram_data      <= '0;
            ram_wren      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lock_lost     <= 1'b0;
            wr_addr       <= '0;
            sample_cnt    <= '0;
            cont_mode     <= 1'b0;
        end else begin
            // NOTE: strobes get a default at the top of the clocked block; each
            // branch below only states what differs in that cycle.
            csr_write     <= 1'b0;
            csr_writedata <= '0;
            ram_wren      <= 1'b0;

            // A sample is written even in the cycle that leaves CAPTURE.
            if (capture_sample) begin
                ram_wren   <= 1'b1;
                ram_addr   <= wr_addr;
                ram_data   <= adc_data;
                wr_addr    <= wr_addr + 1'b1;
                sample_cnt <= sample_cnt + 1'b1;
            end

            // NOTE: non-blocking (<=) everywhere here so every decision uses the
            // pre-edge register values regardless of statement order.
            case (state)
                IDLE, DONE: begin
                    if (start && !stop) begin
                        state     <= WAIT_LOCK;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        lock_lost <= 1'b0;
                    end
                end
                WAIT_LOCK: begin
                    if (stop) begin
                        state         <= CFG_STOP;
                        csr_write     <= 1'b1;
                        csr_writedata <= CSR_STOP_WORD;
                    end else if (enter_run) begin
                        state         <= CFG_RUN;
                        csr_write     <= 1'b1;
                        csr_writedata <= CSR_RUN_WORD;
                        wr_addr       <= '0;
                        sample_cnt    <= '0;
                        lock_lost     <= 1'b0;
                        cont_mode     <= continuous;
                    end
                end
                CFG_RUN: state <= CAPTURE;
                CAPTURE: begin
                    if (stop || !pll_locked ||
                        (!cont_mode && capture_sample && sample_cnt == LAST_SAMPLE)) begin
                        state         <= CFG_STOP;
                        csr_write     <= 1'b1;
                        csr_writedata <= CSR_STOP_WORD;
                        if (!stop && !pll_locked)
                            lock_lost <= 1'b1;
                    end
                end
                CFG_STOP: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    adc_avg_window #(
        .AVG_LOG2(AVG_LOG2)
    ) u_avg (
        .clk         (clk),
        .rst         (rst),
        .clear       (enter_run),
        .sample_valid(capture_sample),
        .sample      (adc_data),
        .avg_out     (avg_out),
        .avg_valid   (avg_valid),
        .led         (led)
    );

endmodule
